dict_hamming_decompressor: RTL and testbench

Downstream neighbour of the Hamming-distance dictionary compressor. Accepts the compressor's stream of codebook indices through a valid/ready handshake and buffers them in a small FIFO. Expands each index into its hardwired 4-bit codeword and re-serializes it MSB-first on a single-bit valid/ready output. The serial output has the same format as the compressor's serial input, so the pair forms a lossy round-trip. It also marks frame boundaries every NUM_CHUNKS chunks.

---
 rtl/dict_hamming_pkg.sv | 27 ++
 rtl/dict_index_fifo.sv | 59 +++++
 rtl/dict_hamming_decompressor.sv | 156 +++++++++++++++
 tb/tb_dict_hamming_decompressor.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dict_hamming_pkg.sv
// Shared codebook, sizes and serializer state for the Hamming dictionary compressor/decompressor pair.
// Both ends import this package so that encode and decode always use the same codewords.
package dict_hamming_pkg;

  localparam int CHUNK_SIZE    = 4;
  localparam int CODEBOOK_SIZE = 8;
  localparam int INDEX_BITS    = $clog2(CODEBOOK_SIZE);

  localparam logic [CHUNK_SIZE-1:0] CODEBOOK [CODEBOOK_SIZE] = '{
    4'b0000, 4'b0001, 4'b1000, 4'b0011,
    4'b1100, 4'b0111, 4'b1110, 4'b1111
  };

  typedef enum logic {
    SER_IDLE  = 1'b0,
    SER_SHIFT = 1'b1
  } ser_state_e;

  // Out-of-range indices decode to all-zero rather than aliasing onto a real entry.
  function automatic logic [CHUNK_SIZE-1:0] cb_lookup(input logic [31:0] idx);
    if (idx < CODEBOOK_SIZE) begin
      return CODEBOOK[idx[INDEX_BITS-1:0]];
    end
    return '0;
  endfunction

endpackage

// File: rtl/dict_index_fifo.sv
// Synchronous index FIFO: write visible the cycle after push, head readable combinationally.
// No internal backpressure; the producer must gate push with !full, the consumer pop with !empty.
module dict_index_fifo #(
  parameter int WIDTH = 3,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_dat,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_dat,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
    if (push) begin
      mem_d[wr_ptr_q] = push_dat;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign pop_dat = mem_q[rd_ptr_q];
  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;

endmodule

// File: rtl/dict_hamming_decompressor.sv
// Expands buffered codebook indices into codewords sent MSB-first; 2 cycles from index to first bit, no bubble between chunks.
// Output holds while data_out_ready=0, index_ready=!fifo_full. DICT_HAMMING_DECOMP_STATS_EN builds the stat_chunks counter.
module dict_hamming_decompressor #(
  parameter int CHUNK_SIZE    = dict_hamming_pkg::CHUNK_SIZE,
  parameter int CODEBOOK_SIZE = dict_hamming_pkg::CODEBOOK_SIZE,
  parameter int INDEX_BITS    = $clog2(CODEBOOK_SIZE),
  parameter int FIFO_DEPTH    = 4,
  parameter int NUM_CHUNKS    = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [INDEX_BITS-1:0] index_in,
  input  logic                  index_valid,
  output logic                  index_ready,
  output logic                  data_out,
  output logic                  data_out_valid,
  input  logic                  data_out_ready,
  output logic                  frame_done,
  output logic [15:0]           stat_chunks
);

  import dict_hamming_pkg::*;

  localparam int BIT_W = (CHUNK_SIZE > 1) ? $clog2(CHUNK_SIZE) : 1;
  localparam int FRM_W = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic                  fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [INDEX_BITS-1:0] fifo_dat;
  logic [CNT_W-1:0]      fifo_count;
  logic                  unused_fifo_count;
  logic [CHUNK_SIZE-1:0] head_word;
  logic                  chunk_done;

  ser_state_e            state_q, state_d;
  logic [CHUNK_SIZE-1:0] shift_q, shift_d;
  logic [BIT_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic [FRM_W-1:0]      frame_cnt_q, frame_cnt_d;
  logic                  frame_done_q, frame_done_d;

  assign index_ready       = !fifo_full;
  assign fifo_push         = index_valid && index_ready;
  assign unused_fifo_count = ^fifo_count;

  dict_index_fifo #(
    .WIDTH (INDEX_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (fifo_push),
    .push_dat (index_in),
    .pop      (fifo_pop),
    .pop_dat  (fifo_dat),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

  assign head_word = (32'(fifo_dat) < CODEBOOK_SIZE) ? CHUNK_SIZE'(cb_lookup(32'(fifo_dat))) : '0;

  always_comb begin
    state_d        = state_q;
    shift_d        = shift_q;
    bit_cnt_d      = bit_cnt_q;
    fifo_pop       = 1'b0;
    chunk_done     = 1'b0;
    data_out       = 1'b0;
    data_out_valid = 1'b0;
    case (state_q)
      SER_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop  = 1'b1;
          shift_d   = head_word;
          bit_cnt_d = '0;
          state_d   = SER_SHIFT;
        end
      end
      SER_SHIFT: begin
        data_out       = shift_q[CHUNK_SIZE-1];
        data_out_valid = 1'b1;
        if (data_out_ready) begin
          shift_d   = shift_q << 1;
          bit_cnt_d = bit_cnt_q + BIT_W'(1);
          if (bit_cnt_q == BIT_W'(CHUNK_SIZE-1)) begin
            chunk_done = 1'b1;
            // Back-to-back reload keeps the serial stream gap-free.
            if (!fifo_empty) begin
              fifo_pop  = 1'b1;
              shift_d   = head_word;
              bit_cnt_d = '0;
            end else begin
              state_d = SER_IDLE;
            end
          end
        end
      end
      default: state_d = SER_IDLE;
    endcase
  end

  always_comb begin
    frame_cnt_d  = frame_cnt_q;
    frame_done_d = 1'b0;
    if (chunk_done) begin
      if (frame_cnt_q == FRM_W'(NUM_CHUNKS-1)) begin
        frame_cnt_d  = '0;
        frame_done_d = 1'b1;
      end else begin
        frame_cnt_d = frame_cnt_q + FRM_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= SER_IDLE;
      shift_q      <= '0;
      bit_cnt_q    <= '0;
      frame_cnt_q  <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      shift_q      <= shift_d;
      bit_cnt_q    <= bit_cnt_d;
      frame_cnt_q  <= frame_cnt_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign frame_done = frame_done_q;

`ifdef DICT_HAMMING_DECOMP_STATS_EN
  logic [15:0] stat_q, stat_d;

  always_comb begin
    stat_d = stat_q;
    if (chunk_done && (stat_q != 16'hFFFF)) begin
      stat_d = stat_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_q <= '0;
    end else begin
      stat_q <= stat_d;
    end
  end

  assign stat_chunks = stat_q;
`else
  assign stat_chunks = '0;
`endif

endmodule

// File: tb/tb_dict_hamming_decompressor.sv
// Directed bench for dict_hamming_decompressor with a bit-queue reference model checked every cycle.
module tb_dict_hamming_decompressor;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  index_in = '0;
  logic        index_valid = 1'b0;
  logic        index_ready;
  logic        data_out;
  logic        data_out_valid;
  logic        data_out_ready = 1'b0;
  logic        frame_done;
  logic [15:0] stat_chunks;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  dict_hamming_decompressor dut (
    .clk            (clk),
    .rst            (rst),
    .index_in       (index_in),
    .index_valid    (index_valid),
    .index_ready    (index_ready),
    .data_out       (data_out),
    .data_out_valid (data_out_valid),
    .data_out_ready (data_out_ready),
    .frame_done     (frame_done),
    .stat_chunks    (stat_chunks)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: expected serial bits, bit/chunk totals since reset.
  logic [3:0] cb [8] = '{4'b0000, 4'b0001, 4'b1000, 4'b0011,
                         4'b1100, 4'b0111, 4'b1110, 4'b1111};
  bit   exp_q[$];
  int   bits_total   = 0;
  int   chunks_total = 0;
  logic fd_exp       = 1'b0;
  logic stall        = 1'b0;
  logic stall_bit    = 1'b0;

  always @(negedge clk) begin
    logic fd_next;
    int   stat_exp;
    if (rst) begin
      exp_q.delete();
      bits_total   = 0;
      chunks_total = 0;
      fd_exp       = 1'b0;
      stall        = 1'b0;
    end else begin
`ifdef DICT_HAMMING_DECOMP_STATS_EN
      stat_exp = (chunks_total > 65535) ? 65535 : chunks_total;
`else
      stat_exp = 0;
`endif
      chk("frame_done", frame_done, fd_exp);
      chk("stat_chunks", stat_chunks, stat_exp);
      if (stall) begin
        chk("hold_valid", data_out_valid, 1);
        chk("hold_bit", data_out, stall_bit);
      end
      fd_next = 1'b0;
      if (data_out_valid && data_out_ready) begin
        chk("bit_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) chk("serial_bit", data_out, exp_q.pop_front());
        bits_total++;
        if (bits_total % 4 == 0) chunks_total++;
        if (bits_total % 16 == 0) fd_next = 1'b1;
      end
      fd_exp    = fd_next;
      stall     = data_out_valid && !data_out_ready;
      stall_bit = data_out;
      if (index_valid && index_ready) begin
        for (int b = 3; b >= 0; b--) exp_q.push_back(cb[index_in][b]);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic push_idx(input logic [2:0] i);
    logic acc;
    acc = 1'b0;
    index_in    = i;
    index_valid = 1'b1;
    for (int k = 0; k < 200 && !acc; k++) begin
      @(negedge clk);
      acc = index_ready;
      tick();
    end
    index_valid = 1'b0;
    chk("push_accept", acc, 1);
  endtask

  task automatic wait_drain(input string name);
    logic done;
    done = 1'b0;
    for (int k = 0; k < 300 && !done; k++) begin
      @(negedge clk);
      if (!data_out_valid && exp_q.size() == 0) done = 1'b1;
    end
    chk(name, done, 1);
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] got16;
    logic [3:0]  got4;
    logic [3:0]  e1;
    logic        ok;
    logic        allv;
    int          n;
    int          pulses;
    int          bits_seen;
    int          bits_at_pulse;

    tick();
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_index_ready", index_ready, 1);
    chk("rst_data_out", data_out, 0);
    chk("rst_valid", data_out_valid, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_stat", stat_chunks, 0);

    // Single index 3: one idle cycle, then 0,0,1,1, then valid drops.
    tick();
    data_out_ready = 1'b1;
    push_idx(3'd3);
    @(negedge clk);
    chk("t1_latency_gap", data_out_valid, 0);
    e1 = 4'b0011;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t1_valid", data_out_valid, 1);
      chk("t1_bit", data_out, e1[3-i]);
    end
    @(negedge clk);
    chk("t1_valid_drop", data_out_valid, 0);

    // Four chunks back to back: gap-free stream and one frame_done.
    tick();
    do_reset();
    fork
      begin
        push_idx(3'd2); push_idx(3'd7); push_idx(3'd0); push_idx(3'd5);
      end
      begin
        ok = 1'b0;
        for (int k = 0; k < 20 && !ok; k++) begin
          @(negedge clk);
          if (data_out_valid) ok = 1'b1;
        end
        chk("t2_start", ok, 1);
        got16 = {15'b0, data_out};
        allv  = 1'b1;
        for (int k = 1; k < 16; k++) begin
          @(negedge clk);
          got16 = {got16[14:0], data_out};
          allv  = allv & data_out_valid;
        end
        chk("t2_stream", got16, 16'b1000_1111_0000_0111);
        chk("t2_no_bubble", allv, 1);
        @(negedge clk);
        chk("t2_frame_done", frame_done, 1);
        @(negedge clk);
        chk("t2_frame_done_once", frame_done, 0);
      end
    join

    // Stalled output: fill the FIFO, check index_ready, then drain.
    tick();
    data_out_ready = 1'b0;
    push_idx(3'd1); push_idx(3'd3); push_idx(3'd4); push_idx(3'd6); push_idx(3'd2);
    @(negedge clk);
    chk("t3_full", index_ready, 0);
    tick();
    index_in    = 3'd7;
    index_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("t3_blocked", index_ready, 0);
      tick();
    end
    index_valid    = 1'b0;
    data_out_ready = 1'b1;
    n  = 0;
    ok = 1'b0;
    for (int k = 0; k < 40 && !ok; k++) begin
      @(negedge clk);
      if (index_ready) ok = 1'b1;
      else if (data_out_valid && data_out_ready) n++;
    end
    chk("t3_ready_back", ok, 1);
    chk("t3_bits_before_ready", n, 4);
    wait_drain("t3_drain");

    // Ready toggling every cycle through index 6.
    data_out_ready = 1'b0;
    push_idx(3'd6);
    ok = 1'b0;
    for (int k = 0; k < 10 && !ok; k++) begin
      @(negedge clk);
      if (data_out_valid) ok = 1'b1;
    end
    chk("t4_start", ok, 1);
    tick();
    got4 = '0;
    n    = 0;
    for (int k = 0; k < 12; k++) begin
      data_out_ready = (k % 2 == 0);
      @(negedge clk);
      if (data_out_valid && data_out_ready) begin
        got4 = {got4[2:0], data_out};
        n++;
      end
      tick();
    end
    chk("t4_bits", got4, 4'b1110);
    chk("t4_count", n, 4);
    data_out_ready = 1'b1;
    wait_drain("t4_drain");

    // Reset two bits into a chunk with three indices queued.
    data_out_ready = 1'b0;
    push_idx(3'd7); push_idx(3'd5); push_idx(3'd3); push_idx(3'd1);
    data_out_ready = 1'b1;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("t5_valid", data_out_valid, 0);
    chk("t5_index_ready", index_ready, 1);
    chk("t5_stat", stat_chunks, 0);
    chk("t5_frame_done", frame_done, 0);
    tick();
    pulses        = 0;
    bits_seen     = 0;
    bits_at_pulse = -1;
    fork
      begin
        push_idx(3'd4); push_idx(3'd2); push_idx(3'd6); push_idx(3'd1);
      end
      begin
        for (int k = 0; k < 40; k++) begin
          @(negedge clk);
          if (frame_done) begin
            pulses++;
            bits_at_pulse = bits_seen;
          end
          if (data_out_valid && data_out_ready) bits_seen++;
        end
      end
    join
    chk("t5_pulses", pulses, 1);
    chk("t5_bits_at_pulse", bits_at_pulse, 16);
    wait_drain("t5_drain");

    // Nine chunks for the statistics counter.
    do_reset();
    data_out_ready = 1'b1;
    for (int i = 0; i < 9; i++) push_idx(3'(i % 8));
    wait_drain("t6_drain");
    @(negedge clk);
`ifdef DICT_HAMMING_DECOMP_STATS_EN
    chk("t6_stat", stat_chunks, 9);
`else
    chk("t6_stat", stat_chunks, 0);
`endif
    chk("model_queue_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
